// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and constants for the register-file scoreboard.
package regfile_scoreboard_pkg;

  // Register file addressing: 15 implemented registers, address 15 is unimplemented.
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned NUM_REGS   = 15;
  localparam logic [REG_ADDR_W-1:0] INVALID_REG = 4'd15;

  // Per-register pending-write counter and stall performance counter widths.
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter (sb_counter): saturating up/down with synchronous clear.
module regfile_scoreboard_sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_inc, do_dec;

  assign full    = (cnt_q == '1);
  assign nonzero = (cnt_q != '0);
  assign cnt     = cnt_q;

  // Next count: a decrement never underflows; an increment at full is only legal with a decrement.
  always_comb begin
    do_dec = dec && nonzero;
    do_inc = inc && (!full || do_dec);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (do_inc && !do_dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_inc && do_dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: RAW / pending-write-saturation issue gating, stall counter, error flag.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_src1,
  input  logic [REG_ADDR_W-1:0] issue_src2,
  input  logic                  issue_use_src2,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic                  err
);

  localparam int unsigned AddrSpace = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0] inc, dec, full, nonzero;
  logic [CNT_W-1:0]    cnt [NUM_REGS];

  // Address-space-wide views; entries for unimplemented addresses stay 0 so they never hazard.
  logic [AddrSpace-1:0] eff_busy, full_held, nz_ext;
  logic                 hazard, fire;
  logic                 err_q, err_d;
  logic [PERF_W-1:0]    stall_q, stall_d;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i] = fire && issue_wb_en && (issue_dest == REG_ADDR_W'(i));
    assign dec[i] = wb_valid && !flush && (wb_dest == REG_ADDR_W'(i));

    regfile_scoreboard_sb_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .clr     (flush),
      .cnt     (cnt[i]),
      .full    (full[i]),
      .nonzero (nonzero[i])
    );
  end

  // Effective busy state: a writeback this cycle is already visible to readers (negedge RF write).
  always_comb begin
    eff_busy  = '0;
    full_held = '0;
    nz_ext    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic wb_hit;
      wb_hit       = wb_valid && (wb_dest == REG_ADDR_W'(i)) && nonzero[i];
      eff_busy[i]  = nonzero[i] && !(wb_hit && (cnt[i] == CNT_W'(1)));
      full_held[i] = full[i] && !wb_hit;
      nz_ext[i]    = nonzero[i];
    end
  end

  // Hazard compare and issue handshake; ready does not depend on issue_valid.
  always_comb begin
    hazard = eff_busy[issue_src1]
          || (issue_use_src2 && eff_busy[issue_src2])
          || (issue_wb_en && full_held[issue_dest]);
    issue_ready = !flush && !hazard;
    fire        = issue_valid && issue_ready;
  end

  // Sticky error on underflow, writeback to 15, or issue to 15; suppressed during flush.
  always_comb begin
    err_d = err_q;
    if (!flush) begin
      if (wb_valid && !nz_ext[wb_dest]) begin
        err_d = 1'b1;
      end
      if (fire && issue_wb_en && (issue_dest == INVALID_REG)) begin
        err_d = 1'b1;
      end
    end
  end

  // Saturating stall counter; flush cycles with a waiting instruction count too.
  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  // Error flag and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign busy_mask    = nonzero;
  assign stall_cycles = stall_q;
  assign err          = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: reference model pushes expected post-edge state, popped after each edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_src2, issue_wb_en, issue_ready;
  logic [3:0]  issue_src1, issue_src2, issue_dest;
  logic        wb_valid, flush, err;
  logic [3:0]  wb_dest;
  logic [14:0] busy_mask;
  logic [15:0] stall_cycles;

  typedef struct {
    logic [14:0] busy;
    logic        err;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  int m_cnt [16];
  bit m_err;
  int m_stall;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_use_src2 (issue_use_src2),
    .issue_wb_en    (issue_wb_en),
    .issue_dest     (issue_dest),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .flush          (flush),
    .busy_mask      (busy_mask),
    .stall_cycles   (stall_cycles),
    .err            (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] model_busy();
    logic [14:0] b;
    b = '0;
    for (int i = 0; i < 15; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_err   = 0;
    m_stall = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_src1 = 0; issue_src2 = 0; issue_use_src2 = 0;
    issue_wb_en = 0; issue_dest = 0; wb_valid = 0; wb_dest = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // One cycle of stimulus: check ready mid-cycle, then compare registered state after the edge.
  task automatic step(input string tag, input bit iv, input int s1, input int s2, input bit us2,
                      input bit wen, input int d, input bit wv, input int wd, input bit fl);
    int   eff [16];
    bit   haz, rdy, fire, wb_free;
    exp_t e, got;
    @(negedge clk);
    issue_valid = iv; issue_src1 = 4'(s1); issue_src2 = 4'(s2); issue_use_src2 = us2;
    issue_wb_en = wen; issue_dest = 4'(d); wb_valid = wv; wb_dest = 4'(wd); flush = fl;
    #1;
    for (int i = 0; i < 16; i++) begin
      eff[i] = m_cnt[i] - ((wv && wd == i && m_cnt[i] != 0) ? 1 : 0);
    end
    wb_free = wv && (wd == d) && (m_cnt[d] != 0);
    haz = (s1 < 15 && eff[s1] != 0) || (us2 && s2 < 15 && eff[s2] != 0)
       || (wen && d < 15 && m_cnt[d] == 3 && !wb_free);
    rdy  = !fl && !haz;
    fire = iv && rdy;
    check_eq({tag, ".ready"}, 32'(issue_ready), 32'(rdy));

    if (iv && !rdy && m_stall < 16'hFFFF) m_stall++;
    if (fl) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      bit do_dec;
      if (wv && (wd >= 15 || m_cnt[wd] == 0)) m_err = 1;
      if (fire && wen && d >= 15) m_err = 1;
      do_dec = wv && wd < 15 && m_cnt[wd] != 0;
      if (fire && wen && d < 15) m_cnt[d]++;
      if (do_dec) m_cnt[wd]--;
    end
    e.busy = model_busy(); e.err = m_err; e.stall = 16'(m_stall);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq({tag, ".busy"}, 32'(busy_mask), 32'(got.busy));
    check_eq({tag, ".err"}, 32'(err), 32'(got.err));
    check_eq({tag, ".stall"}, 32'(stall_cycles), 32'(got.stall));
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check_eq("reset.busy", 32'(busy_mask), 32'h0);
    check_eq("reset.err", 32'(err), 32'h0);
    check_eq("reset.stall", 32'(stall_cycles), 32'h0);
    check_eq("reset.ready", 32'(issue_ready), 32'h1);

    // RAW on reg 3 and same-cycle writeback bypass.
    step("t1_issue3", 1, 0, 0, 0, 1, 3, 0, 0, 0);
    check_eq("t1_busy_0008", 32'(busy_mask), 32'h0008);
    step("t1_raw3", 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step("t1_raw3_wb", 1, 3, 0, 0, 0, 0, 1, 3, 0);

    // Pending-count saturation on reg 5.
    step("t2_a", 1, 0, 0, 0, 1, 5, 0, 0, 0);
    step("t2_b", 1, 0, 0, 0, 1, 5, 0, 0, 0);
    step("t2_c", 1, 0, 0, 0, 1, 5, 0, 0, 0);
    step("t2_full", 1, 0, 0, 0, 1, 5, 0, 0, 0);
    step("t2_full_wb", 1, 0, 0, 0, 1, 5, 1, 5, 0);

    // src2 gating by issue_use_src2.
    step("t3_nouse", 1, 0, 5, 0, 0, 0, 0, 0, 0);
    step("t3_use", 1, 0, 5, 1, 0, 0, 0, 0, 0);
    step("t3_drain1", 0, 0, 0, 0, 0, 0, 1, 5, 0);
    step("t3_drain2", 0, 0, 0, 0, 0, 0, 1, 5, 0);
    step("t3_drain3", 0, 0, 0, 0, 0, 0, 1, 5, 0);

    // Flush discards pending writes and the concurrent issue.
    step("t4_i1", 1, 0, 0, 0, 1, 1, 0, 0, 0);
    step("t4_i2", 1, 0, 0, 0, 1, 2, 0, 0, 0);
    step("t4_i7", 1, 0, 0, 0, 1, 7, 0, 0, 0);
    step("t4_flush", 1, 0, 0, 0, 1, 4, 0, 0, 1);
    step("t4_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Error cases.
    step("t5_underflow", 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step("t5_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    check_eq("t5_err_cleared", 32'(err), 32'h0);
    step("t5_dest15", 1, 0, 0, 0, 1, 15, 0, 0, 0);
    step("t5_wb15_src15", 1, 15, 15, 1, 0, 0, 1, 15, 0);

    // Long stall saturation, then asynchronous reset mid-stall.
    do_reset();
    step("t6_issue2", 1, 0, 0, 0, 1, 2, 0, 0, 0);
    @(negedge clk);
    issue_valid = 1; issue_src1 = 4'd2; issue_wb_en = 0;
    repeat (65541) @(posedge clk);
    #1;
    check_eq("t6_stall_sat", 32'(stall_cycles), 32'hFFFF);
    check_eq("t6_ready_low", 32'(issue_ready), 32'h0);
    check_eq("t6_busy", 32'(busy_mask), 32'h0004);
    #2;
    rst = 1;
    #1;
    check_eq("t6_async_stall", 32'(stall_cycles), 32'h0);
    check_eq("t6_async_busy", 32'(busy_mask), 32'h0);
    check_eq("t6_async_err", 32'(err), 32'h0);
    check_eq("t6_async_ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    rst = 0;
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
